// File: rtl/dec_key_sequencer_pkg.sv
// Shared AES key-schedule definitions.
// Holds the default round count, the round-key width, the index width and
// the key-sequencer state encoding. The encryption key FSM uses the same
// package.
package dec_key_sequencer_pkg;

  localparam int AES_NR    = 10;   // AES-128 round count; must stay <= 15
  localparam int AES_KEY_W = 128;
  localparam int AES_IDX_W = 4;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOADED = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } key_seq_state_e;

endpackage

// File: rtl/dec_key_sequencer_round_key_ram.sv
// round_key_ram: (NR+1) x KEY_W round-key store.
// It has one synchronous write port and one asynchronous read port. The
// storage has no reset, so stale contents stay unreachable until the FSM
// has rewritten them.
// Ports:
//   clk      write clock
//   we_i     write enable
//   waddr_i  write slot
//   wdata_i  write data
//   raddr_i  read slot (combinational read)
//   rdata_o  read data
module round_key_ram
  import dec_key_sequencer_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AES_IDX_W-1:0] waddr_i,
  input  logic [KEY_W-1:0]     wdata_i,
  input  logic [AES_IDX_W-1:0] raddr_i,
  output logic [KEY_W-1:0]     rdata_o
);

  logic [KEY_W-1:0] mem_q [0:NR];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dec_key_sequencer.sv
// dec_key_sequencer: stores the NR+1 forward-order round keys that come
// from key expansion. On request it replays them in reverse order (NR down
// to 0) to the inverse-cipher datapath, using a valid/ready handshake.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   wr_valid/wr_key    incoming round key (index 0 first)
//   wr_ready           high while keys are being collected (EMPTY)
//   clear              drop stored keys and abort; beats every other request
//   start              begin a reverse sequence (legal only in LOADED)
//   rd_ready           datapath consumes the presented key
//   key_valid/key_out/key_idx  presented key, zero outside ISSUE
//   loaded             all NR+1 keys are stored
//   done               one-cycle pulse after key 0 is consumed
//   err                one-cycle pulse after an ignored start or wr_valid
module dec_key_sequencer
  import dec_key_sequencer_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [KEY_W-1:0]     wr_key,
  output logic                 wr_ready,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 rd_ready,
  output logic                 key_valid,
  output logic [KEY_W-1:0]     key_out,
  output logic [AES_IDX_W-1:0] key_idx,
  output logic                 loaded,
  output logic                 done,
  output logic                 err
);

  localparam logic [AES_IDX_W-1:0] LAST = AES_IDX_W'(NR);

  key_seq_state_e       state_q, state_d;
  logic [AES_IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [AES_IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic                 err_q, err_d;
  logic                 ram_we;
  logic [KEY_W-1:0]     ram_rdata;

  round_key_ram #(.NR(NR), .KEY_W(KEY_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_cnt_q),
    .wdata_i (wr_key),
    .raddr_i (rd_idx_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    err_d    = 1'b0;
    ram_we   = 1'b0;
    if (clear) begin
      // Abort without error or done; any write attempted this cycle is dropped.
      state_d  = EMPTY;
      wr_cnt_d = '0;
      rd_idx_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          err_d = start;
          if (wr_valid) begin
            ram_we = 1'b1;
            if (wr_cnt_q == LAST) begin
              state_d  = LOADED;
              wr_cnt_d = '0;
            end else begin
              wr_cnt_d = wr_cnt_q + 4'd1;
            end
          end
        end
        LOADED: begin
          err_d = wr_valid;
          if (start) begin
            state_d  = ISSUE;
            rd_idx_d = LAST;
          end
        end
        ISSUE: begin
          err_d = start | wr_valid;
          if (rd_ready) begin
            if (rd_idx_q == '0) state_d  = DONE;
            else                rd_idx_d = rd_idx_q - 4'd1;
          end
        end
        DONE: begin
          // Start here is rejected, not queued; the next sequence needs LOADED.
          err_d   = start | wr_valid;
          state_d = LOADED;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign wr_ready  = (state_q == EMPTY);
  assign loaded    = (state_q != EMPTY);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign key_valid = (state_q == ISSUE);
  assign key_out   = key_valid ? ram_rdata : '0;
  assign key_idx   = key_valid ? rd_idx_q : '0;

endmodule

// File: doc/dec_key_sequencer.md
DEC_KEY_SEQUENCER -- requirements
Module: dec_key_sequencer

Interface
REQ-001 Parameter NR, default 10, number of AES rounds; the block stores NR+1 round keys.
REQ-002 Parameter KEY_W, default 128, round-key width in bits.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  round key from key expansion is present on wr_key.
REQ-006 wr_key  input  KEY_W  round key; keys arrive in forward order, index 0 first.
REQ-007 wr_ready  output  1  block accepts wr_key this cycle.
REQ-008 clear  input  1  discard stored keys, abort any sequence.
REQ-009 start  input  1  single-cycle request to begin a reverse (decryption) key sequence.
REQ-010 rd_ready  input  1  inverse-cipher datapath consumes the presented key.
REQ-011 key_valid  output  1  key_out/key_idx are valid.
REQ-012 key_out  output  KEY_W  round key for the current inverse round.
REQ-013 key_idx  output  4  index of key_out; counts NR down to 0.
REQ-014 loaded  output  1  all NR+1 keys are stored.
REQ-015 done  output  1  single-cycle pulse after key 0 is consumed.
REQ-016 err  output  1  single-cycle pulse on an illegal request.

Function
REQ-017 The state machine SHALL have states EMPTY, LOADED, ISSUE, DONE.
REQ-018 In EMPTY, wr_ready SHALL be 1; a cycle with wr_valid=1 SHALL write wr_key to slot wr_cnt and increment wr_cnt.
REQ-019 When the write to slot NR completes, the FSM SHALL enter LOADED on the same edge, with wr_cnt reset to 0 and wr_ready low from the next cycle.
REQ-020 loaded SHALL be 1 in LOADED, ISSUE and DONE, and 0 in EMPTY.
REQ-021 In LOADED, start=1 SHALL move to ISSUE with rd_idx=NR; key_valid SHALL rise in the cycle after start (1-cycle latency).
REQ-022 In ISSUE, key_valid SHALL be 1, key_out SHALL equal slot rd_idx, and key_idx SHALL equal rd_idx, all combinational from registered rd_idx.
REQ-023 In ISSUE, with rd_ready=1 and rd_idx>0, rd_idx SHALL decrement by 1; with rd_ready=0, all outputs SHALL hold.
REQ-024 In ISSUE, with rd_ready=1 and rd_idx=0, the FSM SHALL enter DONE; done SHALL be 1 for exactly that one DONE cycle, followed by LOADED.
REQ-025 Stored keys SHALL persist across sequences; a new start in LOADED SHALL replay NR..0 without reloading.
REQ-026 Outside ISSUE, key_valid SHALL be 0, key_out SHALL be all zeros, and key_idx SHALL be 0.
REQ-027 clear=1 in any state SHALL force EMPTY with wr_cnt=0 on the next edge; clear SHALL take priority over start, wr_valid and rd_ready in the same cycle.
REQ-028 start in EMPTY, ISSUE or DONE SHALL be ignored and SHALL pulse err on the next cycle.
REQ-029 wr_valid in any state other than EMPTY SHALL be ignored and SHALL pulse err on the next cycle.
REQ-030 Clearing mid-sequence SHALL drop key_valid on the next cycle, and done SHALL not pulse.
REQ-031 rd_idx and wr_cnt SHALL be 4 bits wide and SHALL never exceed NR; NR is limited to 15 or less.

Reset
REQ-032 Asserting rst SHALL immediately force EMPTY, wr_cnt=0, rd_idx=0, key_valid=0, key_out=0, key_idx=0, loaded=0, done=0, err=0, and wr_ready=1 after reset release.
REQ-033 Key storage SHALL not be reset; its contents are unreachable until rewritten.
REQ-034 Reset asserted during ISSUE SHALL abort the sequence with no done pulse.

Structure
REQ-035 NR, KEY_W and the state encodings SHALL live in the shared AES package/header, also used by the encryption key FSM.
REQ-036 Key storage SHALL be a sub-module, round_key_ram: (NR+1) x KEY_W, one synchronous write port and one asynchronous read port.
REQ-037 The implementation SHALL be a single clocked process plus combinational next-state and output logic; there are no other sub-modules.

Verification
REQ-038 Load 11 keys K[i]=128'h0..0i in consecutive cycles, then pulse start with rd_ready=1 -> key_idx 10,9,...,0 on 11 consecutive cycles with key_out=K[idx], done on the 12th cycle after start, loaded=1 throughout.
REQ-039 Same load, rd_ready toggled 1,0,1,0 -> each key held while rd_ready=0, no index skipped, done exactly once.
REQ-040 start pulsed after only 5 keys are written -> err=1 one cycle, key_valid stays 0, and the 6th write still goes to slot 5.
REQ-041 clear asserted at key_idx=4 together with rd_ready=1 -> key_valid=0 and loaded=0 next cycle, no done, and wr_ready=1.
REQ-042 rst asserted asynchronously mid-load at wr_cnt=7 -> all outputs at reset values without a clock edge; a full reload of 11 keys and replay are then correct.
REQ-043 Two back-to-back start sequences with no reload -> identical key streams, and wr_valid during the second sequence pulses err.
